// File: rtl/tetris_score_pkg.sv
// Shared types and constants for the Tetris scoring engine.
package tetris_score_pkg;

  localparam int unsigned PEND_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StLevel
  } state_e;

  // Base points indexed by lines cleared; entries 0 and 5..7 are invalid events.
  localparam logic [3:0] BASE_POINTS [8] = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd8, 4'd0, 4'd0, 4'd0};

endpackage

// File: rtl/tetris_score_unit_if.sv
// Line-clear event handshake between block_control and the scoring engine.
interface tetris_score_unit_if;
  logic       clear_valid;
  logic [2:0] clear_lines;
  logic       clear_ready;

  modport master (
    output clear_valid,
    output clear_lines,
    input  clear_ready
  );

  modport slave (
    input  clear_valid,
    input  clear_lines,
    output clear_ready
  );
endinterface

// File: rtl/bcd_adder.sv
// Combinational packed-BCD adder with carry out of the top digit.
module bcd_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] i_a,
  input  logic [4*DIGITS-1:0] i_b,
  output logic [4*DIGITS-1:0] o_sum,
  output logic                o_carry
);

  logic [4:0] w_dsum;
  logic       w_c;

  always_comb begin
    o_sum  = '0;
    w_c    = 1'b0;
    w_dsum = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_dsum = {1'b0, i_a[4*i +: 4]} + {1'b0, i_b[4*i +: 4]} + {4'd0, w_c};
      if (w_dsum > 5'd9) begin
        w_dsum = w_dsum + 5'd6;
        w_c    = 1'b1;
      end else begin
        w_c    = 1'b0;
      end
      o_sum[4*i +: 4] = w_dsum[3:0];
    end
    o_carry = w_c;
  end

endmodule

// File: rtl/tetris_score_unit.sv
// Scoring engine: level-weighted line-clear points, soft-drop points, lines/level and high score.
module tetris_score_unit
  import tetris_score_pkg::*;
#(
  parameter int unsigned SCORE_DIGITS    = 6,
  parameter int unsigned LINE_DIGITS     = 3,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  tetris_score_unit_if.slave        clr_if,
  input  logic                      soft_drop,
  input  logic                      game_over,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [4*SCORE_DIGITS-1:0] high_bcd,
  output logic [4*LINE_DIGITS-1:0]  lines_bcd,
  output logic [3:0]                level,
  output logic                      saturated,
  output logic                      busy
);

  localparam int unsigned SW = 4 * SCORE_DIGITS;
  localparam int unsigned LW = 4 * LINE_DIGITS;
  localparam logic [SW-1:0]     SCORE_MAX = {SCORE_DIGITS{4'h9}};
  localparam logic [LW-1:0]     LINES_MAX = {LINE_DIGITS{4'h9}};
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_e            r_state, w_state_nxt;
  logic [SW-1:0]     r_score, w_score_nxt;
  logic [SW-1:0]     r_high, w_high_nxt;
  logic [LW-1:0]     r_lines, w_lines_nxt;
  logic [3:0]        r_level, w_level_nxt;
  logic [4:0]        r_lil, w_lil_nxt;
  logic [PEND_W-1:0] r_pend, w_pend_nxt;
  logic              r_sat, w_sat_nxt;
  logic              r_hs_pend, w_hs_pend_nxt;
  logic [3:0]        r_add_val, w_add_val_nxt;
  logic [4:0]        r_rep, w_rep_nxt;
  logic [2:0]        r_clr_lines, w_clr_lines_nxt;

  logic              w_ready, w_accept, w_lines_ok;
  logic              w_score_en, w_pend_dec, w_direct, w_pend_inc;
  logic [3:0]        w_score_inc;
  logic [SW-1:0]     w_score_b, w_score_sum;
  logic              w_score_cout;
  logic [LW-1:0]     w_lines_b, w_lines_sum;
  logic              w_lines_cout;
  logic [4:0]        w_lil_sum;

  assign w_ready            = (r_state == StIdle) && start;
  assign clr_if.clear_ready = w_ready;
  assign w_accept           = clr_if.clear_valid && w_ready;
  assign w_lines_ok         = (clr_if.clear_lines != 3'd0) && (clr_if.clear_lines <= 3'd4);
  assign w_pend_inc         = soft_drop && !w_direct;
  assign w_lil_sum          = r_lil + {2'b00, r_clr_lines};

  // Select what the score adder adds this cycle; an accepted clear blocks pend draining.
  always_comb begin
    w_score_en  = 1'b0;
    w_score_inc = 4'd0;
    w_pend_dec  = 1'b0;
    w_direct    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_accept) begin
          if (r_pend != '0) begin
            w_score_en  = 1'b1;
            w_score_inc = 4'd1;
            w_pend_dec  = 1'b1;
          end else if (soft_drop) begin
            w_score_en  = 1'b1;
            w_score_inc = 4'd1;
            w_direct    = 1'b1;
          end
        end
      end
      StAdd: begin
        w_score_en  = 1'b1;
        w_score_inc = r_add_val;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_score_b       = '0;
    w_score_b[3:0]  = w_score_inc;
    w_lines_b       = '0;
    w_lines_b[3:0]  = {1'b0, r_clr_lines};
  end

  bcd_adder #(.DIGITS(SCORE_DIGITS)) u_score_add (
    .i_a     (r_score),
    .i_b     (w_score_b),
    .o_sum   (w_score_sum),
    .o_carry (w_score_cout)
  );

  bcd_adder #(.DIGITS(LINE_DIGITS)) u_lines_add (
    .i_a     (r_lines),
    .i_b     (w_lines_b),
    .o_sum   (w_lines_sum),
    .o_carry (w_lines_cout)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_score_nxt     = r_score;
    w_high_nxt      = r_high;
    w_lines_nxt     = r_lines;
    w_level_nxt     = r_level;
    w_lil_nxt       = r_lil;
    w_pend_nxt      = r_pend;
    w_sat_nxt       = r_sat;
    w_hs_pend_nxt   = r_hs_pend;
    w_add_val_nxt   = r_add_val;
    w_rep_nxt       = r_rep;
    w_clr_lines_nxt = r_clr_lines;

    if (w_score_en) begin
      if (w_score_cout || r_sat) begin
        w_score_nxt = SCORE_MAX;
        w_sat_nxt   = 1'b1;
      end else begin
        w_score_nxt = w_score_sum;
      end
    end

    if (w_pend_inc && !w_pend_dec) begin
      if (r_pend != PEND_MAX) w_pend_nxt = r_pend + PEND_W'(1);
    end else if (!w_pend_inc && w_pend_dec) begin
      w_pend_nxt = r_pend - PEND_W'(1);
    end

    unique case (r_state)
      StIdle: begin
        if (w_accept && w_lines_ok) begin
          w_add_val_nxt   = BASE_POINTS[clr_if.clear_lines];
          w_rep_nxt       = {1'b0, r_level} + 5'd1;
          w_clr_lines_nxt = clr_if.clear_lines;
          w_state_nxt     = StAdd;
        end
      end
      StAdd: begin
        w_rep_nxt = r_rep - 5'd1;
        if (r_rep == 5'd1) w_state_nxt = StLevel;
      end
      StLevel: begin
        w_lines_nxt = w_lines_cout ? LINES_MAX : w_lines_sum;
        if (w_lil_sum >= 5'(LINES_PER_LEVEL)) begin
          w_lil_nxt = w_lil_sum - 5'(LINES_PER_LEVEL);
          if (r_level < 4'(MAX_LEVEL)) w_level_nxt = r_level + 4'd1;
        end else begin
          w_lil_nxt = w_lil_sum;
        end
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

    // A deferred compare also resolves on a game clear, against the pre-clear score.
    if ((game_over || r_hs_pend) && ((r_state == StIdle) || !start)) begin
      if (r_score > r_high) w_high_nxt = r_score;
      w_hs_pend_nxt = 1'b0;
    end else if (game_over) begin
      w_hs_pend_nxt = 1'b1;
    end

    if (!start) begin
      w_state_nxt = StIdle;
      w_score_nxt = '0;
      w_lines_nxt = '0;
      w_level_nxt = 4'd0;
      w_lil_nxt   = 5'd0;
      w_pend_nxt  = '0;
      w_sat_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_score     <= '0;
      r_high      <= '0;
      r_lines     <= '0;
      r_level     <= 4'd0;
      r_lil       <= 5'd0;
      r_pend      <= '0;
      r_sat       <= 1'b0;
      r_hs_pend   <= 1'b0;
      r_add_val   <= 4'd0;
      r_rep       <= 5'd0;
      r_clr_lines <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_score     <= w_score_nxt;
      r_high      <= w_high_nxt;
      r_lines     <= w_lines_nxt;
      r_level     <= w_level_nxt;
      r_lil       <= w_lil_nxt;
      r_pend      <= w_pend_nxt;
      r_sat       <= w_sat_nxt;
      r_hs_pend   <= w_hs_pend_nxt;
      r_add_val   <= w_add_val_nxt;
      r_rep       <= w_rep_nxt;
      r_clr_lines <= w_clr_lines_nxt;
    end
  end

  assign score_bcd = r_score;
  assign high_bcd  = r_high;
  assign lines_bcd = r_lines;
  assign level     = r_level;
  assign saturated = r_sat;
  assign busy      = (r_state != StIdle);

endmodule
